eq1_exerciser_amisha: RTL and testbench
=======================================

Name: eq1_exerciser_amisha

Overview:
- Initiator side of the 1-bit equality comparator interface (i0/i1 in, eq out).
- Drives every input pair {i1,i0} = 00, 01, 10, 11 for a configurable number of sweeps.
- Samples the comparator's eq response after a settle window and compares it with the expected value (i0 == i1).
- Reports a mismatch count, the first failing vector and a pass flag. Used as an on-chip self-test for the comparator family.

Parameters:
- SETTLE, 2: extra cycles each vector is held before eq is sampled (legal range ≥ 0).
- ROUNDS, 1: number of complete 4-vector sweeps per run (legal range ≥ 1).
- CNT_W, 8: width of the mismatch counter.

Ports:
- clk_amisha  input  1  clock; all state updates on rising edge.
- rst_n_amisha  input  1  asynchronous, active-low reset.
- start_amisha  input  1  run request; sampled only in IDLE.
- i0_amisha  output  1  comparator operand 0 (= vector bit 0).
- i1_amisha  output  1  comparator operand 1 (= vector bit 1).
- eq_amisha  input  1  comparator response; same clock domain, no synchroniser.
- busy_amisha  output  1  high while a run is in progress.
- done_amisha  output  1  one-cycle pulse at end of run.
- pass_amisha  output  1  1 when the last completed run had zero mismatches.
- err_cnt_amisha  output  CNT_W  mismatch count of current/last run, saturating.
- first_err_valid_amisha  output  1  at least one mismatch recorded this run.
- first_err_vec_amisha  output  2  {i1,i0} of the first mismatch.

Behaviour:
- Reset (async assert, sync release): state IDLE. All outputs are 0, including i0, i1, busy, done, pass, err_cnt, first_err_valid and first_err_vec. Internal counters are 0.
- States: IDLE → RUN → DONE → IDLE.
- IDLE: i0 = i1 = 0, busy = 0. On the rising edge where start = 1 (edge S):
  - enter RUN and set busy = 1;
  - vector index v = 0, settle counter = 0, round counter = 0;
  - clear err_cnt, first_err_valid and first_err_vec, and clear pass.
- RUN, output drive: i1 = v[1], i0 = v[0], registered, changing only on vector-advance edges. Each vector is held for exactly SETTLE+1 cycles.
- RUN, sampling: eq is sampled on the edge that ends the hold window, i.e. edges S+(SETTLE+1)·(n+1) for n = 0 … 4·ROUNDS−1.
  - expected = ~(v[1] ^ v[0]).
  - On a mismatch, err_cnt increments, saturating at 2^CNT_W−1.
  - On the first mismatch of the run, first_err_vec = v and first_err_valid = 1; later mismatches do not overwrite them.
- RUN, advance: on a sample edge v increments (wrapping 11 → 00). The round counter increments when v wraps.
- Last sample edge (v = 11, round = ROUNDS−1): enter DONE with i0 = i1 = 0 and busy = 0.
- DONE: lasts exactly one cycle with done = 1.
  - pass = 1 if err_cnt = 0 including the final sample, else 0.
  - Next edge returns to IDLE. start is not sampled in DONE.
- Holding after a run: pass, err_cnt and first_err_* keep their values until the next accepted start.
- start is ignored while in RUN or DONE (no restart, no queueing).
- start held continuously high: a new run begins on the first IDLE edge, i.e. runs are back-to-back with one DONE cycle and one IDLE cycle between them.
- Run length: busy is high for exactly 4·ROUNDS·(SETTLE+1) cycles. done occurs in the cycle after the last sample edge.
- Reset mid-run: immediate return to IDLE with all outputs 0. No done pulse; the partial result is discarded.
- X on eq_amisha is not filtered. The bench must drive a known value.

Test Plan:
- Ideal comparator model, SETTLE=2, ROUNDS=1, start pulse at edge S:
  - i0/i1 sequence 00, 01, 10, 11 with each vector held 3 cycles;
  - busy high 12 cycles, done pulse in the cycle after S+12;
  - pass = 1, err_cnt = 0, first_err_valid = 0.
- eq stuck at 1, ROUNDS=2: err_cnt = 4, first_err_vec = 01, pass = 0, first_err_valid = 1.
- eq stuck at 0, SETTLE=0, ROUNDS=1: vectors change every cycle; err_cnt = 2, first_err_vec = 00, busy high 4 cycles.
- Saturation: CNT_W=2, ROUNDS=4, eq stuck at 1 → err_cnt = 3 (not 8), pass = 0.
- Comparator with 2-cycle response delay, SETTLE=0: mismatches detected, err_cnt ≠ 0. Rerun with SETTLE=2 → pass = 1, err_cnt = 0.
- Control:
  - start pulsed during RUN is ignored, and run length is unchanged.
  - start held high produces back-to-back runs with exactly 2 cycles of busy = 0 between them.
  - rst_n asserted mid-RUN drives all outputs to 0 asynchronously with no done pulse; after release, a new start runs normally.

Source files
------------

// File: rtl/eq1_exerciser_amisha.sv
// Built-in self-test initiator for 1-bit equality comparators: sweeps {i1,i0}
// through 00..11, samples eq after a settle window and reports mismatches.
module eq1_exerciser_amisha #(
  parameter int SETTLE = 2,
  parameter int ROUNDS = 1,
  parameter int CNT_W  = 8
) (
  input  logic             clk_amisha,
  input  logic             rst_n_amisha,
  input  logic             start_amisha,
  output logic             i0_amisha,
  output logic             i1_amisha,
  input  logic             eq_amisha,
  output logic             busy_amisha,
  output logic             done_amisha,
  output logic             pass_amisha,
  output logic [CNT_W-1:0] err_cnt_amisha,
  output logic             first_err_valid_amisha,
  output logic [1:0]       first_err_vec_amisha
);

  localparam int SET_W = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
  localparam int RND_W = (ROUNDS < 2) ? 1 : $clog2(ROUNDS);
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE);
  localparam logic [RND_W-1:0] ROUND_LAST  = RND_W'(ROUNDS - 1);
  localparam logic [CNT_W-1:0] ERR_MAX     = '1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [1:0]       vec;
  logic [SET_W-1:0] settle_cnt;
  logic [RND_W-1:0] round_cnt;
  logic             sample, last_sample, mismatch;

  assign sample      = (state == RUN) && (settle_cnt == SETTLE_LAST);
  assign last_sample = sample && (vec == 2'b11) && (round_cnt == ROUND_LAST);
  assign mismatch    = sample && (eq_amisha != ~(vec[1] ^ vec[0]));

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_amisha) state_next = RUN;
      RUN:     if (last_sample) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_amisha or negedge rst_n_amisha) begin
    if (!rst_n_amisha) state <= IDLE;
    else               state <= state_next;
  end

  always_ff @(posedge clk_amisha or negedge rst_n_amisha) begin
    if (!rst_n_amisha) begin
      vec                    <= 2'b00;
      settle_cnt             <= '0;
      round_cnt              <= '0;
      err_cnt_amisha         <= '0;
      first_err_valid_amisha <= 1'b0;
      first_err_vec_amisha   <= 2'b00;
      pass_amisha            <= 1'b0;
    end else if (state == IDLE && start_amisha) begin
      vec                    <= 2'b00;
      settle_cnt             <= '0;
      round_cnt              <= '0;
      err_cnt_amisha         <= '0;
      first_err_valid_amisha <= 1'b0;
      first_err_vec_amisha   <= 2'b00;
      pass_amisha            <= 1'b0;
    end else if (state == RUN) begin
      if (sample) begin
        settle_cnt <= '0;
        // vec wraps to 00 on the last sample, which also parks i0/i1 low
        vec <= vec + 2'd1;
        if (last_sample)        round_cnt <= '0;
        else if (vec == 2'b11)  round_cnt <= round_cnt + 1'b1;
        if (mismatch) begin
          if (err_cnt_amisha != ERR_MAX) err_cnt_amisha <= err_cnt_amisha + 1'b1;
          if (!first_err_valid_amisha) begin
            first_err_valid_amisha <= 1'b1;
            first_err_vec_amisha   <= vec;
          end
        end
        if (last_sample) pass_amisha <= (err_cnt_amisha == '0) && !mismatch;
      end else begin
        settle_cnt <= settle_cnt + 1'b1;
      end
    end
  end

  assign i0_amisha   = vec[0];
  assign i1_amisha   = vec[1];
  assign busy_amisha = (state == RUN);
  assign done_amisha = (state == DONE);

endmodule

// File: tb/tb_eq1_exerciser_amisha.sv
// Directed bench for eq1_exerciser_amisha: four parameterisations driven by
// selectable comparator models (ideal, stuck-1, stuck-0, 2-cycle delayed).
module tb_eq1_exerciser_amisha;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [3:0] start_v;
  logic [3:0] eq_v;
  wire  [3:0] i0_w, i1_w, busy_w, done_w, pass_w, fev_w;
  wire  [1:0] fvec_w [4];
  wire  [7:0] err_w [4];
  wire  [1:0] err_d;

  // dut 0: SETTLE=2 ROUNDS=1; dut 1: SETTLE=2 ROUNDS=2;
  // dut 2: SETTLE=0 ROUNDS=1; dut 3: SETTLE=0 ROUNDS=4 CNT_W=2
  eq1_exerciser_amisha #(.SETTLE(2), .ROUNDS(1), .CNT_W(8)) dut_a (
    .clk_amisha(clk), .rst_n_amisha(rst_n), .start_amisha(start_v[0]),
    .i0_amisha(i0_w[0]), .i1_amisha(i1_w[0]), .eq_amisha(eq_v[0]),
    .busy_amisha(busy_w[0]), .done_amisha(done_w[0]), .pass_amisha(pass_w[0]),
    .err_cnt_amisha(err_w[0]), .first_err_valid_amisha(fev_w[0]),
    .first_err_vec_amisha(fvec_w[0]));

  eq1_exerciser_amisha #(.SETTLE(2), .ROUNDS(2), .CNT_W(8)) dut_b (
    .clk_amisha(clk), .rst_n_amisha(rst_n), .start_amisha(start_v[1]),
    .i0_amisha(i0_w[1]), .i1_amisha(i1_w[1]), .eq_amisha(eq_v[1]),
    .busy_amisha(busy_w[1]), .done_amisha(done_w[1]), .pass_amisha(pass_w[1]),
    .err_cnt_amisha(err_w[1]), .first_err_valid_amisha(fev_w[1]),
    .first_err_vec_amisha(fvec_w[1]));

  eq1_exerciser_amisha #(.SETTLE(0), .ROUNDS(1), .CNT_W(8)) dut_c (
    .clk_amisha(clk), .rst_n_amisha(rst_n), .start_amisha(start_v[2]),
    .i0_amisha(i0_w[2]), .i1_amisha(i1_w[2]), .eq_amisha(eq_v[2]),
    .busy_amisha(busy_w[2]), .done_amisha(done_w[2]), .pass_amisha(pass_w[2]),
    .err_cnt_amisha(err_w[2]), .first_err_valid_amisha(fev_w[2]),
    .first_err_vec_amisha(fvec_w[2]));

  eq1_exerciser_amisha #(.SETTLE(0), .ROUNDS(4), .CNT_W(2)) dut_d (
    .clk_amisha(clk), .rst_n_amisha(rst_n), .start_amisha(start_v[3]),
    .i0_amisha(i0_w[3]), .i1_amisha(i1_w[3]), .eq_amisha(eq_v[3]),
    .busy_amisha(busy_w[3]), .done_amisha(done_w[3]), .pass_amisha(pass_w[3]),
    .err_cnt_amisha(err_d), .first_err_valid_amisha(fev_w[3]),
    .first_err_vec_amisha(fvec_w[3]));

  assign err_w[3] = {6'd0, err_d};

  // comparator models: 0 ideal, 1 stuck at 1, 2 stuck at 0, 3 ideal delayed 2 cycles
  int         mode [4];
  logic [3:0] d1 = '1;
  logic [3:0] d2 = '1;

  always @(posedge clk) begin
    d1 <= ~(i1_w ^ i0_w);
    d2 <= d1;
  end

  always_comb begin
    eq_v = '0;
    for (int k = 0; k < 4; k++) begin
      case (mode[k])
        0:       eq_v[k] = ~(i1_w[k] ^ i0_w[k]);
        1:       eq_v[k] = 1'b1;
        2:       eq_v[k] = 1'b0;
        default: eq_v[k] = d2[k];
      endcase
    end
  end

  typedef struct {
    int    k;
    int    mode;
    int    len;
    int    err;
    int    pass;
    int    fvalid;
    int    fvec;
    string name;
  } vec_t;

  vec_t       tbl [6];
  int         n_checks = 0;
  int         n_pass   = 0;
  logic [1:0] obs [64];

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  function automatic int all_out(input int k);
    return int'({busy_w[k], done_w[k], pass_w[k], i0_w[k], i1_w[k],
                 fev_w[k], fvec_w[k], err_w[k]});
  endfunction

  // Pulse start for one cycle, then follow the run; t=0 is the cycle after edge S.
  task automatic run_one(input int k, input int repulse_t,
                         output int busy_n, output int done_t);
    busy_n = 0;
    done_t = -1;
    @(negedge clk);
    start_v[k] = 1'b1;
    @(negedge clk);
    start_v[k] = 1'b0;
    for (int t = 0; t < 400; t++) begin
      if (t > 0) @(negedge clk);
      start_v[k] = (t == repulse_t);
      if (t < 64) obs[t] = {i1_w[k], i0_w[k]};
      if (busy_w[k]) busy_n++;
      if (done_w[k]) begin
        done_t = t;
        break;
      end
    end
    start_v[k] = 1'b0;
  endtask

  initial begin
    int b, d, n1, n0, n2, g, done_seen;
    int hold_err, hold_pass;

    rst_n   = 1'b0;
    start_v = '0;
    for (int k = 0; k < 4; k++) mode[k] = 0;

    tbl[0] = '{0, 0, 12, 0, 1, 0, 0, "ideal_s2_r1"};
    tbl[1] = '{1, 1, 24, 4, 0, 1, 1, "stuck1_s2_r2"};
    tbl[2] = '{2, 2,  4, 2, 0, 1, 0, "stuck0_s0_r1"};
    tbl[3] = '{3, 1, 16, 3, 0, 1, 1, "saturate_cntw2_r4"};
    tbl[4] = '{2, 3,  4, 3, 0, 1, 1, "delay2_s0"};
    tbl[5] = '{0, 3, 12, 0, 1, 0, 0, "delay2_s2"};

    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) chk($sformatf("reset_outputs_dut%0d", k), all_out(k), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_release", all_out(0), 0);

    for (int r = 0; r < 6; r++) begin
      mode[tbl[r].k] = tbl[r].mode;
      run_one(tbl[r].k, -1, b, d);
      $display("run %s: busy=%0d done_at=%0d err=%0d pass=%0d fvalid=%0d fvec=%0d",
               tbl[r].name, b, d, err_w[tbl[r].k], pass_w[tbl[r].k],
               fev_w[tbl[r].k], fvec_w[tbl[r].k]);
      chk({tbl[r].name, "_busy_len"}, b, tbl[r].len);
      chk({tbl[r].name, "_done_at"}, d, tbl[r].len);
      chk({tbl[r].name, "_err_cnt"}, int'(err_w[tbl[r].k]), tbl[r].err);
      chk({tbl[r].name, "_pass"}, int'(pass_w[tbl[r].k]), tbl[r].pass);
      chk({tbl[r].name, "_first_valid"}, int'(fev_w[tbl[r].k]), tbl[r].fvalid);
      chk({tbl[r].name, "_first_vec"}, int'(fvec_w[tbl[r].k]), tbl[r].fvec);
      @(negedge clk);
      chk({tbl[r].name, "_done_one_cycle"}, int'(done_w[tbl[r].k]), 0);
      chk({tbl[r].name, "_hold_err"}, int'(err_w[tbl[r].k]), tbl[r].err);
      chk({tbl[r].name, "_hold_pass"}, int'(pass_w[tbl[r].k]), tbl[r].pass);
    end

    // drive sequence: each vector held SETTLE+1 = 3 cycles
    mode[0] = 0;
    run_one(0, -1, b, d);
    $display("run vector_sequence: busy=%0d done_at=%0d", b, d);
    for (int t = 0; t < 12; t++) chk($sformatf("vec_seq_t%0d", t), int'(obs[t]), t / 3);
    chk("vec_parked_in_done", int'(obs[12]), 0);

    // start pulses inside the run are ignored
    run_one(0, 5, b, d);
    $display("run restart_mid: busy=%0d done_at=%0d", b, d);
    chk("restart_mid_len", b, 12);
    chk("restart_mid_done_at", d, 12);
    run_one(0, 11, b, d);
    $display("run restart_last: busy=%0d done_at=%0d", b, d);
    chk("restart_last_len", b, 12);
    repeat (2) @(negedge clk);
    chk("restart_not_queued", int'(busy_w[0]), 0);

    // start held high: back-to-back runs with 2 idle cycles between
    @(negedge clk);
    start_v[0] = 1'b1;
    n1 = 0; n0 = 0; n2 = 0; g = 0;
    while (!busy_w[0] && g < 50) begin @(negedge clk); g++; end
    while (busy_w[0] && g < 200) begin n1++; @(negedge clk); g++; end
    while (!busy_w[0] && g < 200) begin n0++; @(negedge clk); g++; end
    start_v[0] = 1'b0;
    while (busy_w[0] && g < 300) begin n2++; @(negedge clk); g++; end
    $display("run start_held: busy1=%0d gap=%0d busy2=%0d", n1, n0, n2);
    chk("held_run1_len", n1, 12);
    chk("held_gap", n0, 2);
    chk("held_run2_len", n2, 12);
    repeat (3) @(negedge clk);
    chk("held_stops_after_release", int'(busy_w[0]), 0);

    // asynchronous reset in the middle of a run
    mode[0] = 1;
    @(negedge clk);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (7) @(negedge clk);
    chk("midrun_err_before_reset", int'(err_w[0]), 1);
    chk("midrun_i1_before_reset", int'(i1_w[0]), 1);
    #2 rst_n = 1'b0;
    #1;
    $display("run reset_midrun: outputs=%0d", all_out(0));
    chk("async_reset_outputs", all_out(0), 0);
    done_seen = 0;
    repeat (2) begin
      @(negedge clk);
      done_seen = done_seen | int'(done_w[0]);
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      done_seen = done_seen | int'(done_w[0]) | int'(busy_w[0]);
    end
    chk("no_done_after_reset", done_seen, 0);

    mode[0] = 0;
    run_one(0, -1, b, d);
    hold_err  = int'(err_w[0]);
    hold_pass = int'(pass_w[0]);
    $display("run after_reset: busy=%0d done_at=%0d err=%0d pass=%0d", b, d, hold_err, hold_pass);
    chk("after_reset_len", b, 12);
    chk("after_reset_done_at", d, 12);
    chk("after_reset_err", hold_err, 0);
    chk("after_reset_pass", hold_pass, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
